// File: rtl/regfile_dump_unit_if.sv
// Port bundle for regfile_dump_unit: control, register-file read port and output stream.
// The master side is the dump unit; the slave side is the core/consumer environment.
interface regfile_dump_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, rf_data, out_ready,
        output rf_addr, out_valid, out_data, out_index, out_last, busy, done
    );

    modport slave (
        output start, abort, rf_data, out_ready,
        input  rf_addr, out_valid, out_data, out_index, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump_unit.sv
// Walks the register file through a spare combinational read port and streams each register
// out over a valid/ready channel, one READ cycle and one SEND cycle per word.
module regfile_dump_unit #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_dump_unit_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [ADDR_W-1:0] r_out_index;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    // abort beats start; start is only looked at here
                    if (bus.start && !bus.abort) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRead;
                    end
                end
                StRead: begin
                    if (bus.abort) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else begin
                        r_out_data  <= bus.rf_data;
                        r_out_index <= r_idx;
                        r_out_last  <= (r_idx == LastIdx);
                        r_out_valid <= 1'b1;
                        r_state     <= StSend;
                    end
                end
                StSend: begin
                    // abort wins over a same-cycle handshake: the word is not consumed
                    if (bus.abort) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= StRead;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.rf_addr   = r_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
